uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single transmitter of `top_Uart` among `N_REQ` byte-stream requesters.
- Grants by round-robin and keeps the grant for a whole packet, up to a burst limit.
- Sequences the UART start/busy handshake for each byte.
- Sits between the application-side producers and the UART TX port of the `if_to_Uart` interface.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `DATA_W`, 8, byte width sent to the UART
- `MAX_BURST`, 16, maximum bytes per grant before forced rotation (1..256)
- `BUSY_TO`, 8, cycles allowed for `uart_tx_busy` to rise after a start pulse

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  requester i has a byte on its data lane
- `req_data`  in  N_REQ*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- `req_last`  in  N_REQ  byte on lane i ends its packet
- `req_ready`  out  N_REQ  one-hot pulse: byte on lane i consumed this cycle
- `uart_tx_start`  out  1  one-cycle start pulse to UART
- `uart_tx_data`  out  DATA_W  byte to UART, stable from LOAD until byte completes
- `uart_tx_busy`  in  1  UART transmitting
- `grant_valid`  out  1  a requester currently owns the UART
- `grant_id`  out  $clog2(N_REQ)  owning requester
- `err_timeout`  out  1  sticky: busy never rose; cleared only by reset

## Operation
- States:
  - IDLE: `grant_valid`=0.
  - LOAD: `req_ready[g]`=1; capture data and last.
  - START: `uart_tx_start`=1.
  - WAIT_BUSY.
  - WAIT_DONE.
  - HOLD.
- IDLE → LOAD when any `req_valid`:
  - Winner = first set bit scanning from `rr_ptr` upward with wrap.
  - Register `grant_id`; set `grant_valid`; clear `burst_cnt`.
- LOAD → START unconditionally; `burst_cnt` += 1.
- START → WAIT_BUSY.
- WAIT_BUSY:
  - `uart_tx_busy`=1 → WAIT_DONE.
  - After `BUSY_TO` cycles without busy: set `err_timeout`, release grant, → IDLE.
- WAIT_DONE, on `uart_tx_busy`=0:
  - Captured last=1 or `burst_cnt`==`MAX_BURST`: release grant, `rr_ptr` = `grant_id`+1 mod N_REQ, → IDLE.
  - Else if `req_valid[g]` → LOAD.
  - Else → HOLD.
- HOLD → LOAD on `req_valid[g]`:
  - Waits indefinitely; requesters must not stall mid-packet.
  - Other requesters' valids are ignored.
- Only `req_valid[g]` matters while granted; other lanes' valids never produce `req_ready`.
- `req_ready` depends on state only, never combinationally on `req_valid`.
- Release: `grant_valid` falls the cycle after WAIT_DONE/WAIT_BUSY exit; `grant_id` holds its last value.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - All outputs 0: `req_ready`, `uart_tx_start`, `uart_tx_data`, `grant_valid`, `grant_id`, `err_timeout`.
- Reset asserted mid-byte: `uart_tx_start` and `req_ready` drop asynchronously; the byte in flight is abandoned.
- First-byte latency: `req_valid` seen in IDLE at edge 0 → `req_ready` high cycle 1 → `uart_tx_start` high cycle 2.
- Back-to-back bytes in a packet: `uart_tx_busy` falling at edge k → `req_ready` cycle k+1 → start cycle k+2.
- Simultaneous valids: only the winner gets `req_ready`; the others hold.
- Wrap: `rr_ptr`=N_REQ-1 after release → next scan starts at 0.
- `burst_cnt` is $clog2(MAX_BURST+1) bits and never exceeds `MAX_BURST`.

## Structure
- Package `uart_arb_pkg` holds:
  - state enum `arb_state_e` (IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, HOLD);
  - default parameter constants;
  - function `id_w(n)` = $clog2(n).
- Sub-module `rr_arbiter`:
  - combinational rotate-priority encoder;
  - inputs: request vector, `rr_ptr`;
  - outputs: `gnt_id`, `gnt_any`.
- FSM, counters and data register live in `uart_tx_arbiter`.
- Bench instantiates `top_Uart` on the TX side with its standard interface.

## Test plan
- Single packet: lane 1 sends 0x41,0x42(last) → two start pulses with data 0x41 then 0x42; `grant_id`=1 throughout; `rr_ptr`=2 after.
- Contention: lanes 0 and 2 each request a 1-byte packet (last) in the same cycle from reset → lane 0 served first, lane 2 second; lane 2 sees no `req_ready` until lane 0 releases.
- Burst limit: `MAX_BURST`=4, lane 3 offers a 6-byte packet while lane 0 waits → 4 bytes from lane 3, then lane 0 (wrap), then lane 3 resumes.
- Busy timeout: `uart_tx_busy` tied 0 → `err_timeout`=1 exactly `BUSY_TO` cycles after WAIT_BUSY entry; `grant_valid`=0; next request is still served.
- HOLD: lane 2 deasserts valid for 10 cycles mid-packet while lane 1 valid → no `req_ready[1]` during the gap; lane 2 resumes on the same grant.
- Reset mid-operation: `rst_n` low during WAIT_DONE → all outputs 0 immediately; after release, `rr_ptr`=0 and lane 0 wins a tie with lane 3.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states
//   DEF_*       : default parameter values
//   id_w(n)     : width of a requester index for n requesters
package uart_arb_pkg;

   localparam int unsigned DEF_N_REQ     = 4;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_MAX_BURST = 16;
   localparam int unsigned DEF_BUSY_TO   = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      HOLD
   } arb_state_e;

   function automatic int unsigned id_w(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder.
//   req     : request vector
//   rr_ptr  : index with highest priority this round
//   gnt_id  : first set request at or above rr_ptr, wrapping
//   gnt_any : at least one request set
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned  N_REQ = DEF_N_REQ,
   localparam int unsigned ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_any
);

   // Scan from the lowest priority upward so the highest-priority hit is written last.
   always_comb begin
      int idx;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
         if (req[ID_W'(idx)]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters.
// Round-robin grant held for a whole packet (at most MAX_BURST bytes),
// with the UART start/busy handshake sequenced per byte.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid/data/last, req_ready : per-lane byte streams, ready is a one-cycle consume pulse
//   uart_tx_start/data, uart_tx_busy : UART TX handshake
//   grant_valid, grant_id           : current owner
//   err_timeout     : sticky, busy never rose after a start pulse
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = DEF_N_REQ,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST,
   parameter int unsigned BUSY_TO   = DEF_BUSY_TO
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      uart_tx_start,
   output logic [DATA_W-1:0]         uart_tx_data,
   input  logic                      uart_tx_busy,
   output logic                      grant_valid,
   output logic [id_w(N_REQ)-1:0]    grant_id,
   output logic                      err_timeout
);

   localparam int unsigned ID_W    = id_w(N_REQ);
   localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
   localparam int unsigned TO_W    = $clog2(BUSY_TO + 1);

   arb_state_e          state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     gid_q, gid_d;
   logic                gv_q, gv_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                last_q, last_d;
   logic [N_REQ-1:0]    ready_q, ready_d;
   logic                start_q, start_d;
   logic                err_q, err_d;

   logic [ID_W-1:0]     arb_id_c;
   logic                arb_any_c;
   logic [ID_W-1:0]     sel_id_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic                sel_last_c;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .gnt_id  (arb_id_c),
      .gnt_any (arb_any_c)
   );

   // Lane feeding the next LOAD: the round-robin winner from IDLE, else the owner.
   always_comb begin
      sel_id_c   = (state_q == IDLE) ? arb_id_c : gid_q;
      sel_data_c = '0;
      sel_last_c = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (sel_id_c == ID_W'(i)) begin
            sel_data_c = req_data[i*DATA_W +: DATA_W];
            sel_last_c = req_last[i];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gid_d    = gid_q;
      gv_d     = gv_q;
      burst_d  = burst_q;
      to_d     = to_q;
      data_d   = data_q;
      last_d   = last_q;
      err_d    = err_q;
      ready_d  = '0;
      start_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_any_c) begin
               state_d = LOAD;
               gid_d   = arb_id_c;
               gv_d    = 1'b1;
               burst_d = '0;
            end
         end
         LOAD: begin
            state_d = START;
            burst_d = burst_q + BURST_W'(1);
            start_d = 1'b1;
         end
         START: begin
            state_d = WAIT_BUSY;
            to_d    = '0;
         end
         WAIT_BUSY: begin
            if (uart_tx_busy) begin
               state_d = WAIT_DONE;
            end else if (to_q == TO_W'(BUSY_TO - 1)) begin
               state_d = IDLE;
               gv_d    = 1'b0;
               err_d   = 1'b1;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!uart_tx_busy) begin
               if (last_q || (burst_q == BURST_W'(MAX_BURST))) begin
                  state_d  = IDLE;
                  gv_d     = 1'b0;
                  rr_ptr_d = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + ID_W'(1);
               end else if (req_valid[gid_q]) begin
                  state_d = LOAD;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (req_valid[gid_q]) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase

      // Entering LOAD: consume the selected lane and latch its byte for the whole transfer.
      if (state_d == LOAD) begin
         ready_d = N_REQ'(1) << sel_id_c;
         data_d  = sel_data_c;
         last_d  = sel_last_c;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gid_q    <= '0;
         gv_q     <= 1'b0;
         burst_q  <= '0;
         to_q     <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         ready_q  <= '0;
         start_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gid_q    <= gid_d;
         gv_q     <= gv_d;
         burst_q  <= burst_d;
         to_q     <= to_d;
         data_q   <= data_d;
         last_q   <= last_d;
         ready_q  <= ready_d;
         start_q  <= start_d;
         err_q    <= err_d;
      end
   end

   assign req_ready     = ready_q;
   assign uart_tx_start = start_q;
   assign uart_tx_data  = data_q;
   assign grant_valid   = gv_q;
   assign grant_id      = gid_q;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 lanes, MAX_BURST=4, BUSY_TO=8,
// with a small UART model raising busy two cycles after each start pulse.
module tb_uart_tx_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            uart_tx_start;
   logic [DW-1:0]   uart_tx_data;
   logic            uart_tx_busy;
   logic            grant_valid;
   logic [1:0]      grant_id;
   logic            err_timeout;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4), .BUSY_TO(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .uart_tx_start (uart_tx_start),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_busy  (uart_tx_busy),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .err_timeout   (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // UART model: busy high for 4 cycles, starting 2 cycles after a start pulse.
   logic       uart_en;
   logic [3:0] u_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       u_cnt <= 4'd0;
      else if (uart_tx_start && uart_en) u_cnt <= 4'd6;
      else if (u_cnt != 4'd0)           u_cnt <= u_cnt - 4'd1;
   end
   assign uart_tx_busy = (u_cnt != 4'd0) && (u_cnt <= 4'd4);

   // Requester lanes: each holds a queue of {last, data}; head byte popped once consumed.
   logic [8:0] lane_q [N][$];
   logic [N-1:0] rdy_seen;

   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         rdy_seen = req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(N); i++) begin
            if (rdy_seen[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            req_valid[i] = (lane_q[i].size() > 0);
            if (lane_q[i].size() > 0) begin
               req_data[i*DW +: DW] = lane_q[i][0][7:0];
               req_last[i]          = lane_q[i][0][8];
            end
         end
      end
   end

   // Monitor: log consumed lanes and transmitted {owner, byte}; ready must go to the owner only.
   int         ready_log[$];
   logic [9:0] start_log[$];
   always @(negedge clk) begin
      if (rst_n && req_ready != '0) begin
         check("ready_owner", 32'($onehot(req_ready) && grant_valid && req_ready[grant_id]), 32'd1);
         for (int i = 0; i < int'(N); i++) if (req_ready[i]) ready_log.push_back(i);
      end
      if (rst_n && uart_tx_start) start_log.push_back({grant_id, uart_tx_data});
   end

   function automatic logic [31:0] sl(input int i);
      return (start_log.size() > i) ? 32'(start_log[i]) : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] rl(input int i);
      return (ready_log.size() > i) ? 32'(ready_log[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic push(input int lane, input logic [7:0] d, input logic last);
      lane_q[lane].push_back({last, d});
   endtask

   task automatic clear_logs();
      ready_log.delete();
      start_log.delete();
   endtask

   task automatic wait_idle(input string tag);
      int  cyc = 0;
      bit  done = 1'b0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         done = (lane_q[0].size() == 0) && (lane_q[1].size() == 0) &&
                (lane_q[2].size() == 0) && (lane_q[3].size() == 0) && !grant_valid;
      end
      check(tag, 32'(done), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_start(input string tag);
      int cyc = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         seen = uart_tx_start;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_start"}, 32'(uart_tx_start), 32'd0);
      check({tag, "_data"},  32'(uart_tx_data), 32'd0);
      check({tag, "_gv"},    32'(grant_valid), 32'd0);
      check({tag, "_gid"},   32'(grant_id), 32'd0);
      check({tag, "_err"},   32'(err_timeout), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < int'(N); i++) lane_q[i].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
   endtask

   initial begin
      rst_n   = 1'b0;
      uart_en = 1'b1;

      // Reset state
      @(negedge clk);
      check_zero_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Single packet on lane 1, with first-byte latency
      @(negedge clk);
      clear_logs();
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b1);
      @(negedge clk);
      check("lat_ready0", 32'(req_ready), 32'd0);
      check("lat_gv0", 32'(grant_valid), 32'd0);
      @(negedge clk);
      check("lat_ready1", 32'(req_ready), 32'h2);
      check("lat_gv1", 32'(grant_valid), 32'd1);
      check("lat_gid1", 32'(grant_id), 32'd1);
      check("lat_start1", 32'(uart_tx_start), 32'd0);
      @(negedge clk);
      check("lat_start2", 32'(uart_tx_start), 32'd1);
      check("lat_data2", 32'(uart_tx_data), 32'h41);
      wait_idle("pkt_idle");
      check("pkt_n", 32'(start_log.size()), 32'd2);
      check("pkt_b0", sl(0), 32'h141);
      check("pkt_b1", sl(1), 32'h142);

      // Pointer now at 2: lanes 0,1,2 tie -> 2, then wrap to 0, then 1
      clear_logs();
      push(0, 8'hB0, 1'b1);
      push(1, 8'hB1, 1'b1);
      push(2, 8'hB2, 1'b1);
      wait_idle("rr_idle");
      check("rr_n", 32'(ready_log.size()), 32'd3);
      check("rr_0", rl(0), 32'd2);
      check("rr_1", rl(1), 32'd0);
      check("rr_2", rl(2), 32'd1);

      // Contention from reset: lanes 0 and 2
      do_reset();
      push(0, 8'hC0, 1'b1);
      push(2, 8'hC2, 1'b1);
      wait_idle("cont_idle");
      check("cont_r0", rl(0), 32'd0);
      check("cont_r1", rl(1), 32'd2);
      check("cont_s0", sl(0), 32'h0C0);
      check("cont_s1", sl(1), 32'h2C2);

      // Burst limit: pointer at 3, lane 3 offers 6 bytes, lane 0 waiting
      clear_logs();
      for (int b = 0; b < 6; b++) push(3, 8'(8'h30 + b), (b == 5));
      push(0, 8'hA0, 1'b1);
      wait_idle("burst_idle");
      check("burst_n", 32'(start_log.size()), 32'd7);
      check("burst_0", sl(0), 32'h330);
      check("burst_3", sl(3), 32'h333);
      check("burst_4", sl(4), 32'h0A0);
      check("burst_5", sl(5), 32'h334);
      check("burst_6", sl(6), 32'h335);

      // HOLD: lane 2 stalls mid-packet while lane 1 waits
      clear_logs();
      push(2, 8'h50, 1'b0);
      wait_start("hold_start");
      push(1, 8'h60, 1'b1);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check("hold_gap_ready", 32'(req_ready), 32'd0);
      end
      check("hold_gv", 32'(grant_valid), 32'd1);
      check("hold_gid", 32'(grant_id), 32'd2);
      push(2, 8'h51, 1'b0);
      push(2, 8'h52, 1'b1);
      wait_idle("hold_idle");
      check("hold_n", 32'(start_log.size()), 32'd4);
      check("hold_1", sl(1), 32'h251);
      check("hold_2", sl(2), 32'h252);
      check("hold_3", sl(3), 32'h160);

      // Busy timeout: pointer at 2, lane 0 served, UART silent
      clear_logs();
      uart_en = 1'b0;
      push(0, 8'h70, 1'b1);
      wait_start("to_start");
      repeat (8) @(negedge clk);
      check("to_err_early", 32'(err_timeout), 32'd0);
      check("to_gv_early", 32'(grant_valid), 32'd1);
      @(negedge clk);
      check("to_err", 32'(err_timeout), 32'd1);
      check("to_gv", 32'(grant_valid), 32'd0);
      uart_en = 1'b1;
      push(1, 8'h71, 1'b1);
      wait_idle("to_idle");
      check("to_n", 32'(start_log.size()), 32'd2);
      check("to_after", sl(1), 32'h171);
      check("to_sticky", 32'(err_timeout), 32'd1);

      // Reset during WAIT_DONE, then lane 0 beats lane 3 from a cleared pointer
      clear_logs();
      push(0, 8'h80, 1'b0);
      push(0, 8'h81, 1'b1);
      begin
         int cyc = 0;
         while (!uart_tx_busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         check("mid_busy", 32'(uart_tx_busy), 32'd1);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < int'(N); i++) lane_q[i].delete();
      #1;
      check_zero_outputs("mid_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      @(negedge clk);
      push(0, 8'h90, 1'b1);
      push(3, 8'h93, 1'b1);
      wait_idle("post_idle");
      check("post_r0", rl(0), 32'd0);
      check("post_r1", rl(1), 32'd3);
      check("post_s0", sl(0), 32'h090);
      check("post_s1", sl(1), 32'h393);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
